lap_display_ctrl: RTL and testbench
===================================

# lap_display_ctrl

Controller for the display-path 2:1 multiplexer in the stopwatch. It detects rising edges on the debounced lap button and captures the running time into a lap register. For a fixed hold window it drives the multiplexer select so the frozen lap value is shown; afterwards it reverts to the live count. It sits between the button debouncer, the stopwatch counter and the display-path multiplexer, whose `a0` is the live time and `a1` is `lap_val`.

## Interface
- `WIDTH`, 16: bits of time value (4 BCD digits).
- `HOLD_CYCLES`, 200: cycles the lap value stays selected after a capture; legal range ≥1.
- `CNT_W`, 4: width of the lap counter.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `lap_btn`  in  1  debounced lap button level, synchronous to `clk`.
- `clear`  in  1  synchronous active-high stopwatch clear.
- `live_time`  in  WIDTH  current stopwatch count.
- `sel`  out  1  multiplexer select: 0 = live, 1 = lap.
- `lap_val`  out  WIDTH  captured lap time; drives multiplexer `a1`.
- `lap_cnt`  out  CNT_W  number of accepted laps, modulo 2^CNT_W.
- `lap_evt`  out  1  one-cycle pulse per accepted lap.

## Operation
- Edge detect: register `btn_q` holds the previous `lap_btn`. An edge is `lap_btn & ~btn_q`. `btn_q` resets to 1, so a button held through reset release produces no edge until it is released and pressed again.
- FSM states:
  - LIVE: `sel` = 0.
  - SHOW: `sel` = 1.
- Hold counter `hold` has width `$clog2(HOLD_CYCLES+1)`.
- Priority per cycle, highest first: `rst_n` = 0, then `clear`, then edge, then hold countdown.
- Accepted edge, in either state:
  - `lap_val` ← `live_time`.
  - `lap_cnt` ← `lap_cnt`+1, wrapping from 2^CNT_W−1 to 0.
  - `lap_evt` ← 1.
  - `hold` ← HOLD_CYCLES−1.
  - Next state is SHOW.
  - An edge during SHOW retriggers: new capture and full hold window restarted.
- SHOW without an edge:
  - If `hold` = 0, next state is LIVE.
  - Otherwise `hold` ← `hold`−1.
- LIVE without an edge: hold state; `hold` is not updated.
- `clear` = 1:
  - Next state is LIVE.
  - `lap_val` ← 0, `lap_cnt` ← 0, `lap_evt` ← 0, `hold` ← 0.
  - Any coincident edge is discarded.
  - `btn_q` still updates, so that press does not re-fire next cycle.
- `lap_evt` is 0 in every cycle not following an accepted edge.
- Reset (`rst_n` = 0 at a clock edge), valid from any state including mid-hold:
  - State is LIVE, `sel` = 0.
  - `lap_val` = 0, `lap_cnt` = 0, `lap_evt` = 0, `hold` = 0.
  - `btn_q` = 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Capture latency: an edge sampled at clock edge k gives the following after k:
  - `sel` = 1.
  - `lap_val` equals `live_time` as sampled at k.
  - `lap_cnt` incremented.
  - `lap_evt` = 1 for exactly that one cycle.
- Hold window: with no further edges, `sel` stays 1 for exactly HOLD_CYCLES cycles, then returns to 0.
- HOLD_CYCLES = 1: `sel` is high for a single cycle.
- Retrigger at SHOW cycle j: `sel` stays high continuously and falls HOLD_CYCLES cycles after the retriggering edge.
- `lap_val` holds its value after the return to LIVE until the next capture or clear.
- `live_time` changes have no effect on `lap_val` except at a capture edge.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `lap_btn` = 1, then release with the button still held → `sel` = 0, `lap_cnt` = 0, `lap_val` = 0, no `lap_evt`. Drop and re-raise `lap_btn` → capture occurs.
- Basic lap (HOLD_CYCLES = 4): `live_time` = 16'h0123, pulse `lap_btn` → next cycle `lap_val` = 16'h0123, `lap_evt` = 1 for one cycle, `lap_cnt` = 1. `sel` = 1 for exactly 4 cycles, then 0. `lap_val` is still 16'h0123.
- Retrigger: second press 2 cycles into SHOW with `live_time` = 16'h0130 → `lap_val` = 16'h0130, `lap_cnt` = 2. `sel` stays high for 4 cycles after the second press with no gap.
- Clear priority: assert `clear` in the same cycle as a press during SHOW → next cycle `sel` = 0, `lap_val` = 0, `lap_cnt` = 0, `lap_evt` = 0. No capture on the following cycle while the button stays high.
- Counter wrap (CNT_W = 4): 16 separated presses → `lap_cnt` reads 15 after the 15th press and 0 after the 16th. `lap_evt` count equals 16.
- Reset mid-hold: drive `rst_n` = 0 at hold cycle 2 → next cycle all outputs are at reset values. A new press after release gives a full 4-cycle window.

Source files
------------

// File: rtl/lap_display_ctrl.sv
// Lap capture and display-mux select for the stopwatch.
// A lap press freezes live_time and selects it for HOLD_CYCLES cycles.
module lap_display_ctrl #(
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 200,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lap_btn,
    input  logic             clear,
    input  logic [WIDTH-1:0] live_time,
    output logic             sel,
    output logic [WIDTH-1:0] lap_val,
    output logic [CNT_W-1:0] lap_cnt,
    output logic             lap_evt
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {
        LIVE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             btn_q;
    logic             press;
    logic [HW-1:0]    hold, hold_nxt;
    logic [WIDTH-1:0] val_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             evt_nxt;

    assign press = lap_btn & ~btn_q;
    assign sel   = (state == SHOW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LIVE;
            btn_q   <= 1'b1;
            hold    <= '0;
            lap_val <= '0;
            lap_cnt <= '0;
            lap_evt <= 1'b0;
        end else begin
            state   <= state_nxt;
            btn_q   <= lap_btn;
            hold    <= hold_nxt;
            lap_val <= val_nxt;
            lap_cnt <= cnt_nxt;
            lap_evt <= evt_nxt;
        end
    end

    // clear outranks a press, and a press outranks the countdown
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        val_nxt   = lap_val;
        cnt_nxt   = lap_cnt;
        evt_nxt   = 1'b0;
        if (clear) begin
            state_nxt = LIVE;
            hold_nxt  = '0;
            val_nxt   = '0;
            cnt_nxt   = '0;
        end else if (press) begin
            state_nxt = SHOW;
            hold_nxt  = HW'(HOLD_CYCLES - 1);
            val_nxt   = live_time;
            cnt_nxt   = lap_cnt + CNT_W'(1);
            evt_nxt   = 1'b1;
        end else if (state == SHOW) begin
            if (hold == '0) begin
                state_nxt = LIVE;
            end else begin
                hold_nxt = hold - HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lap_display_ctrl.sv
// Directed bench for lap_display_ctrl with a cycle-level reference model.
// A second instance with HOLD_CYCLES = 1 covers the single-cycle window.
module tb_lap_display_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lap_btn;
    logic             clear;
    logic [WIDTH-1:0] live_time;
    logic             sel, sel1;
    logic [WIDTH-1:0] lap_val, lap_val1;
    logic [CNT_W-1:0] lap_cnt, lap_cnt1;
    logic             lap_evt, lap_evt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lap_display_ctrl #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .lap_btn(lap_btn), .clear(clear),
        .live_time(live_time), .sel(sel), .lap_val(lap_val),
        .lap_cnt(lap_cnt), .lap_evt(lap_evt)
    );

    lap_display_ctrl #(.WIDTH(WIDTH), .HOLD_CYCLES(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .lap_btn(lap_btn), .clear(clear),
        .live_time(live_time), .sel(sel1), .lap_val(lap_val1),
        .lap_cnt(lap_cnt1), .lap_evt(lap_evt1)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining cycles of lap display, plain integers
    int         m_rem, m_rem1;
    int         m_cnt;
    logic [15:0] m_val;
    logic       m_evt;
    logic       m_prev;
    bit         m_ok = 0;
    int         dut_evts = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem = 0; m_rem1 = 0; m_cnt = 0; m_val = 0; m_evt = 0; m_prev = 1;
        end else begin
            logic pr;
            pr = lap_btn && !m_prev;
            m_prev = lap_btn;
            m_evt = 0;
            if (clear) begin
                m_rem = 0; m_rem1 = 0; m_cnt = 0; m_val = 0;
            end else if (pr) begin
                m_val = live_time;
                m_cnt = (m_cnt + 1) % 16;
                m_evt = 1;
                m_rem = HOLD;
                m_rem1 = 1;
            end else begin
                if (m_rem > 0) m_rem--;
                if (m_rem1 > 0) m_rem1--;
            end
        end
        m_ok = 1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("sel", 32'(sel), 32'(m_rem > 0));
            check("lap_val", 32'(lap_val), 32'(m_val));
            check("lap_cnt", 32'(lap_cnt), 32'(m_cnt));
            check("lap_evt", 32'(lap_evt), 32'(m_evt));
            check("sel_h1", 32'(sel1), 32'(m_rem1 > 0));
            check("lap_cnt_h1", 32'(lap_cnt1), 32'(m_cnt));
            if (lap_evt) dut_evts++;
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e0;
        int n;
        rst_n = 0; lap_btn = 1; clear = 0; live_time = 0;
        step(2);
        rst_n = 1;
        step(1);
        check("rst_sel", 32'(sel), 0);
        check("rst_cnt", 32'(lap_cnt), 0);
        check("rst_val", 32'(lap_val), 0);
        check("rst_evt", 32'(lap_evt), 0);
        lap_btn = 0; step(1);
        live_time = 16'h0055; lap_btn = 1; step(1);
        check("rearm_evt", 32'(lap_evt), 1);
        check("rearm_val", 32'(lap_val), 32'h0055);
        lap_btn = 0; step(6);

        clear = 1; step(1); clear = 0;
        live_time = 16'h0123; lap_btn = 1; step(1);
        check("basic_val", 32'(lap_val), 32'h0123);
        check("basic_cnt", 32'(lap_cnt), 1);
        check("basic_sel", 32'(sel), 1);
        check("h1_sel", 32'(sel1), 1);
        lap_btn = 0; live_time = 16'h0999; step(1);
        check("basic_evt_once", 32'(lap_evt), 0);
        check("h1_sel_drop", 32'(sel1), 0);
        step(2);
        check("basic_sel_c4", 32'(sel), 1);
        step(1);
        check("basic_sel_end", 32'(sel), 0);
        check("basic_val_kept", 32'(lap_val), 32'h0123);

        live_time = 16'h0123; lap_btn = 1; step(1);
        lap_btn = 0; step(1);
        live_time = 16'h0130; lap_btn = 1; step(1);
        check("retrig_val", 32'(lap_val), 32'h0130);
        check("retrig_cnt", 32'(lap_cnt), 3);
        lap_btn = 0; step(3);
        check("retrig_sel_c4", 32'(sel), 1);
        step(1);
        check("retrig_sel_end", 32'(sel), 0);

        live_time = 16'h0200; lap_btn = 1; step(1);
        lap_btn = 0; step(1);
        lap_btn = 1; clear = 1; step(1);
        check("clr_sel", 32'(sel), 0);
        check("clr_val", 32'(lap_val), 0);
        check("clr_cnt", 32'(lap_cnt), 0);
        check("clr_evt", 32'(lap_evt), 0);
        clear = 0; step(1);
        check("clr_no_refire", 32'(lap_evt), 0);
        lap_btn = 0; step(1);

        e0 = dut_evts;
        for (int i = 1; i <= 16; i++) begin
            live_time = 16'(i); lap_btn = 1; step(1);
            if (i == 15) check("wrap_15", 32'(lap_cnt), 15);
            if (i == 16) check("wrap_0", 32'(lap_cnt), 0);
            lap_btn = 0; step(1);
        end
        step(6);
        check("wrap_evts", 32'(dut_evts - e0), 16);

        live_time = 16'h0777; lap_btn = 1; step(1);
        lap_btn = 0; step(1);
        rst_n = 0; step(1);
        check("mid_rst_sel", 32'(sel), 0);
        check("mid_rst_val", 32'(lap_val), 0);
        check("mid_rst_cnt", 32'(lap_cnt), 0);
        rst_n = 1; step(1);
        lap_btn = 1; step(1);
        lap_btn = 0;
        n = (sel === 1'b1) ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (sel === 1'b1) n++;
        end
        check("post_rst_window", 32'(n), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
